// File: rtl/sub_serial_pkg.sv
// Shared ALU package for the serial subtractor.
// Holds word width, FSM states, flag bundle and the full-adder cell.
package sub_serial_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } flags_t;

  // Full-adder cell: returns {carry, sum}
  function automatic logic [1:0] full_add(
    input logic a,
    input logic b,
    input logic c
  );
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/sub_serial_chunk.sv
// One CHUNK-wide slice of X + ~Y + cin.
// Ripple chain of full-adder cells.
module sub_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  import sub_serial_pkg::*;

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign {c[i+1], sum[i]} = full_add(a[i], ~b[i], c[i]);
  end

  assign cout = c[W];

endmodule

// File: rtl/sub_serial.sv
// Multi-cycle 64-bit subtractor, CHUNK bits per clock.
// Optional flags via SUB_SERIAL_FLAGS_EN (zf/sf/of tied 0 otherwise).
module sub_serial #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] X,
  input  logic [63:0] Y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] Z,
  output logic        cout,
  output logic        zf,
  output logic        sf,
  output logic        of
);
  import sub_serial_pkg::*;

  localparam int N = WORD_W / CHUNK;
  localparam logic [6:0] LAST = 7'(N - 1);

  if (!(CHUNK == 1 || CHUNK == 2 || CHUNK == 4 ||
        CHUNK == 8 || CHUNK == 16 || CHUNK == 32 ||
        CHUNK == 64)) begin : g_bad_chunk
    $error("sub_serial: illegal CHUNK");
  end

  state_t      state;
  logic [63:0] x_q;
  logic [63:0] y_q;
  logic [63:0] z_q;
  logic [6:0]  idx;
  logic        carry;
  logic        cout_q;

  logic [CHUNK-1:0] xs;
  logic [CHUNK-1:0] ys;
  logic [CHUNK-1:0] s;
  logic             c_out;
  logic [63:0]      z_full;
  logic             last;

  // Select the current slice and merge its sum into the result word
  always_comb begin
    xs = x_q[idx*CHUNK +: CHUNK];
    ys = y_q[idx*CHUNK +: CHUNK];
    z_full = z_q;
    z_full[idx*CHUNK +: CHUNK] = s;
  end

  assign last = (state == RUN) && (idx == LAST);

  sub_chunk #(
    .W(CHUNK)
  ) u_chunk (
    .a   (xs),
    .b   (ys),
    .cin (carry),
    .sum (s),
    .cout(c_out)
  );

  // Control FSM with operand, result, index and borrow registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            x_q   <= X;
            y_q   <= Y;
            idx   <= '0;
            carry <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          z_q   <= z_full;
          carry <= c_out;
          idx   <= idx + 7'd1;
          if (idx == LAST) begin
            cout_q <= c_out;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign Z         = z_q;
  assign cout      = cout_q;

`ifdef SUB_SERIAL_FLAGS_EN
  flags_t flags_q;

  // Capture condition codes from the completed word on the last slice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (last) begin
      flags_q.zf <= (z_full == 64'd0);
      flags_q.sf <= z_full[63];
      flags_q.of <= (x_q[63] != y_q[63]) &&
                    (z_full[63] != x_q[63]);
    end
  end

  assign zf = flags_q.zf;
  assign sf = flags_q.sf;
  assign of = flags_q.of;
`else
  logic unused_last;
  assign unused_last = last;
  assign zf = 1'b0;
  assign sf = 1'b0;
  assign of = 1'b0;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial.
// Flag expectations follow SUB_SERIAL_FLAGS_EN; CHUNK set by parameter.
module tb_sub_serial;

  parameter int CHUNK = 8;
  localparam int N = 64 / CHUNK;
`ifdef SUB_SERIAL_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] X;
  logic [63:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] Z;
  logic        cout;
  logic        zf;
  logic        sf;
  logic        of;

  int total = 0;
  int bad = 0;

  sub_serial #(
    .CHUNK(CHUNK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .Y        (Y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (Z),
    .cout     (cout),
    .zf       (zf),
    .sf       (sf),
    .of       (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands until accepted, scramble them, then wait for result
  task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                        output int lat);
    int w;
    @(negedge clk);
    X = a;
    Y = b;
    in_valid = 1'b1;
    w = 0;
    while (in_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    X = ~a;
    Y = ~b;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    X = '0;
    Y = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (Z !== 64'd0) begin bad++; $display("FAIL reset_z got=%h exp=0", Z); end
    total++; if ({cout, zf, sf, of} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {cout, zf, sf, of}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    run_op(64'd5, 64'd3, lat);
    total++; if (lat !== N) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, N); end
    total++; if (Z !== 64'd2) begin bad++; $display("FAIL basic_z got=%h exp=2", Z); end
    total++; if ({cout, zf, sf, of} !== 4'b1000) begin bad++; $display("FAIL basic_flags got=%b exp=1000", {cout, zf, sf, of}); end
    ack();
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL basic_ack got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_negative();
    int lat;
    run_op(64'd0, 64'd1, lat);
    total++; if (Z !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL neg_z got=%h exp=ffffffffffffffff", Z); end
    total++; if ({cout, zf, sf, of} !== {1'b0, 1'b0, FL, 1'b0}) begin bad++; $display("FAIL neg_flags got=%b exp=%b", {cout, zf, sf, of}, {1'b0, 1'b0, FL, 1'b0}); end
    ack();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(64'h8000_0000_0000_0000, 64'd1, lat);
    total++; if (Z !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL ovf_z got=%h exp=7fffffffffffffff", Z); end
    total++; if ({cout, zf, sf, of} !== {1'b1, 1'b0, 1'b0, FL}) begin bad++; $display("FAIL ovf_flags got=%b exp=%b", {cout, zf, sf, of}, {1'b1, 1'b0, 1'b0, FL}); end
    ack();
  endtask

  task automatic test_equal();
    int lat;
    run_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, lat);
    total++; if (Z !== 64'd0) begin bad++; $display("FAIL eq_z got=%h exp=0", Z); end
    total++; if ({cout, zf, sf, of} !== {1'b1, FL, 1'b0, 1'b0}) begin bad++; $display("FAIL eq_flags got=%b exp=%b", {cout, zf, sf, of}, {1'b1, FL, 1'b0, 1'b0}); end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(64'd1000, 64'd1, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      X = 64'd7;
      Y = 64'd10;
      @(posedge clk);
      #1;
      total++; if ({out_valid, in_ready} !== 2'b10) begin bad++; $display("FAIL bp_hs[%0d] got=%b exp=10", i, {out_valid, in_ready}); end
      total++; if (Z !== 64'd999 || cout !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b exp=3e7/1", i, Z, cout); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    run_op(64'd7, 64'd10, lat);
    total++; if (Z !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL bp_next_z got=%h exp=fffffffffffffffd", Z); end
    total++; if ({cout, sf} !== {1'b0, FL}) begin bad++; $display("FAIL bp_next_flags got=%b exp=%b", {cout, sf}, {1'b0, FL}); end
    ack();
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    run_op(64'd50, 64'd8, lat);
    total++; if (Z !== 64'd42) begin bad++; $display("FAIL b2b_first got=%h exp=2a", Z); end
    run_op(64'd3, 64'd3, lat);
    total++; if (lat !== N) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, N); end
    total++; if (Z !== 64'd0 || zf !== FL) begin bad++; $display("FAIL b2b_second got=%h/%b exp=0/%b", Z, zf, FL); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    X = 64'd1000;
    Y = 64'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL mid_rst_hs got=%b exp=01", {out_valid, in_ready}); end
    total++; if (Z !== 64'd0 || {cout, zf, sf, of} !== 4'b0) begin bad++; $display("FAIL mid_rst_out got=%h/%b exp=0/0000", Z, {cout, zf, sf, of}); end
    @(negedge clk);
    rst = 1'b0;
    run_op(64'd100, 64'd58, lat);
    total++; if (lat !== N) begin bad++; $display("FAIL mid_next_latency got=%0d exp=%0d", lat, N); end
    total++; if (Z !== 64'd42 || cout !== 1'b1) begin bad++; $display("FAIL mid_next_z got=%h/%b exp=2a/1", Z, cout); end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_equal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
